padded_pixel_streamer: RTL

//  Frame writer for the 3x3 window line buffer. On start, it walks one IMAGE_SIZE x IMAGE_SIZE channel in raster order.
//  It reads the channel from feature-map SRAM (1-cycle read latency) and inserts PADDING rings of zeros.
//  It emits (IMAGE_SIZE+2*PADDING)^2 pixels on a valid/ready stream. Line buffer wr_en = out_valid & out_ready.

---
 rtl/padded_pixel_streamer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/padded_pixel_streamer.sv
// padded_pixel_streamer: raster-order channel reader that wraps each frame in PADDING zero rings
// and streams the pixels through a 2-entry valid/ready buffer. Define PAD_STREAM_EOL_EN for out_eol/out_eof.
module padded_pixel_streamer #(
    parameter int unsigned IMAGE_SIZE = 224,
    parameter int unsigned PADDING    = 1,
    parameter int unsigned DATA_W     = 14,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef PAD_STREAM_EOL_EN
    output logic              out_eol,
    output logic              out_eof,
`endif
    output logic              busy,
    output logic              done
);
    localparam int unsigned PADDED = IMAGE_SIZE + 2 * PADDING;
    localparam int unsigned CW     = $clog2(PADDED) + 1;
    localparam logic [CW-1:0] C_LAST = CW'(PADDED - 1);
    localparam logic [CW-1:0] C_PAD  = CW'(PADDING);
    localparam logic [CW-1:0] C_IMG  = CW'(IMAGE_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t            r_state, w_next;
    logic [CW-1:0]     r_row, r_col;
    logic [ADDR_W-1:0] r_addr;
    logic              r_pipe_valid, r_pipe_pad;
    logic [DATA_W-1:0] r_fifo_data [2];
    logic              r_rd_ptr, r_wr_ptr;
    logic [1:0]        r_count;
    logic              r_done;
`ifdef PAD_STREAM_EOL_EN
    logic              r_pipe_eol, r_pipe_eof;
    logic              r_fifo_eol [2];
    logic              r_fifo_eof [2];
`endif

    logic              w_pop, w_can_issue, w_issue, w_interior, w_last_col, w_last_pos, w_last_pop;
    logic [1:0]        w_occ;
    logic [CW-1:0]     w_row_off, w_col_off;
    logic [DATA_W-1:0] w_push_data;

    assign out_valid   = (r_count != 2'd0);
    assign w_pop       = out_valid && out_ready;
    assign w_occ       = r_count + {1'b0, r_pipe_valid};
    assign w_can_issue = (w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop);
    assign w_issue     = (r_state == S_RUN) && w_can_issue;
    // Offsets wrap below zero, so one unsigned compare per axis tests both pad bands.
    assign w_row_off   = r_row - C_PAD;
    assign w_col_off   = r_col - C_PAD;
    assign w_interior  = (w_row_off < C_IMG) && (w_col_off < C_IMG);
    assign w_last_col  = (r_col == C_LAST);
    assign w_last_pos  = w_last_col && (r_row == C_LAST);
    assign w_last_pop  = w_pop && (r_count == 2'd1) && !r_pipe_valid;
    assign w_push_data = r_pipe_pad ? '0 : mem_rd_data;

    assign mem_rd_en   = w_issue && w_interior;
    assign mem_rd_addr = mem_rd_en ? r_addr : '0;
    assign out_data    = out_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
`ifdef PAD_STREAM_EOL_EN
    assign out_eol     = out_valid && r_fifo_eol[r_rd_ptr];
    assign out_eof     = out_valid && r_fifo_eof[r_rd_ptr];
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_issue && w_last_pos) w_next = S_DRAIN;
            S_DRAIN: if (w_last_pop) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row        <= '0;
            r_col        <= '0;
            r_addr       <= '0;
            r_pipe_valid <= 1'b0;
            r_pipe_pad   <= 1'b0;
            r_done       <= 1'b0;
`ifdef PAD_STREAM_EOL_EN
            r_pipe_eol   <= 1'b0;
            r_pipe_eof   <= 1'b0;
`endif
        end else begin
            r_done       <= (r_state == S_DRAIN) && w_last_pop;
            r_pipe_valid <= w_issue;
            if (w_issue) begin
                r_pipe_pad <= !w_interior;
`ifdef PAD_STREAM_EOL_EN
                r_pipe_eol <= w_last_col;
                r_pipe_eof <= w_last_pos;
`endif
            end
            if ((r_state == S_IDLE) && start) begin
                r_row  <= '0;
                r_col  <= '0;
                r_addr <= base_addr;
            end else if (w_issue) begin
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= r_row + CW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
                // Interior pixels are contiguous in SRAM, so a running pointer replaces the multiply.
                if (w_interior) r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_rd_ptr       <= 1'b0;
            r_wr_ptr       <= 1'b0;
            r_count        <= 2'd0;
`ifdef PAD_STREAM_EOL_EN
            r_fifo_eol[0]  <= 1'b0;
            r_fifo_eol[1]  <= 1'b0;
            r_fifo_eof[0]  <= 1'b0;
            r_fifo_eof[1]  <= 1'b0;
`endif
        end else begin
            if (r_pipe_valid) begin
                r_fifo_data[r_wr_ptr] <= w_push_data;
`ifdef PAD_STREAM_EOL_EN
                r_fifo_eol[r_wr_ptr]  <= r_pipe_eol;
                r_fifo_eof[r_wr_ptr]  <= r_pipe_eof;
`endif
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({r_pipe_valid, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
